// File: rtl/digit_serial_mul_ctrl_pkg.sv
// Shared types for the digit-serial multiplier: FSM encoding and the digit width
// handled by the multiplier cell.
package digit_serial_mul_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int MUL_CELL_W = 2;

endpackage

// File: rtl/digit_serial_mul_ctrl_mul2x2_cell.sv
// Combinational 2-bit x 2-bit -> 4-bit unsigned multiplier from AND partial
// products and half-adder carries.
module mul2x2_cell
    import digit_serial_mul_ctrl_pkg::*;
(
    input  logic [MUL_CELL_W-1:0]   a_i,
    input  logic [MUL_CELL_W-1:0]   b_i,
    output logic [2*MUL_CELL_W-1:0] p_o
);

    logic pp0, pp1, pp2, pp3;
    logic c1, c2;

    assign pp0 = a_i[0] & b_i[0];
    assign pp1 = a_i[1] & b_i[0];
    assign pp2 = a_i[0] & b_i[1];
    assign pp3 = a_i[1] & b_i[1];

    // Column 1 and column 2 are each a half adder; column 3 is the final carry.
    assign c1 = pp1 & pp2;
    assign c2 = pp3 & c1;

    assign p_o = {c2, pp3 ^ c1, pp1 ^ pp2, pp0};

endmodule

// File: rtl/digit_serial_mul_ctrl.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier: one 2x2 cell is time-shared over
// (WIDTH/2)^2 cycles, with valid/ready handshakes on both sides.
module digit_serial_mul_ctrl
    import digit_serial_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int D  = WIDTH / MUL_CELL_W;
    localparam int PW = 2 * WIDTH;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int SW = IW + 2;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("digit_serial_mul_ctrl: WIDTH must be even and >= 2");
    end

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d, prod_q, prod_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d;

    logic [MUL_CELL_W-1:0]   a_dig, b_dig;
    logic [2*MUL_CELL_W-1:0] cell_p;
    logic [SW-1:0]           shamt;
    logic [PW-1:0]           pp_sh;

    assign a_dig = a_q[{i_q, 1'b0} +: MUL_CELL_W];
    assign b_dig = b_q[{j_q, 1'b0} +: MUL_CELL_W];

    mul2x2_cell u_cell (
        .a_i (a_dig),
        .b_i (b_dig),
        .p_o (cell_p)
    );

    // Digit weight is 4^(i+j), i.e. a left shift by 2*(i+j).
    assign shamt = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
    assign pp_sh = PW'(cell_p) << shamt;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        i_d       = i_q;
        j_d       = j_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy  = 1'b1;
                acc_d = acc_q + pp_sh;
                if (i_q == LAST) begin
                    i_d = '0;
                    if (j_q == LAST) begin
                        j_d     = '0;
                        prod_d  = acc_d;
                        state_d = DONE;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Kept separate from the accumulator so the last result survives the next accept.
    assign product = prod_q;

endmodule

// File: tb/tb_digit_serial_mul_ctrl.sv
// Scoreboard bench: accepted operands push hand-computed products; output monitors
// pop and compare value, latency and hold-stability. WIDTH=4 and WIDTH=8 instances.
module tb_digit_serial_mul_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- WIDTH=4 instance ----------------
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0] a, b;
    logic [7:0] product;

    digit_serial_mul_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    logic [15:0] pend4;
    logic [15:0] eq4[$];
    int          cq4[$];
    logic        ovp4 = 1'b0;
    logic [15:0] held4, e4;
    int          c4;

    always @(posedge clk)
        if (rst_n && in_valid && in_ready) begin
            eq4.push_back(pend4);
            cq4.push_back(cyc);
        end

    always @(negedge clk) begin
        if (out_valid && !ovp4) begin
            if (eq4.size() == 0) check("w4_unexpected_out_valid", 1, 0);
            else begin
                e4 = eq4.pop_front();
                c4 = cq4.pop_front();
                check("w4_product", {24'd0, product}, {16'd0, e4});
                check("w4_latency", cyc - c4 - 1, 4);
                held4 = {8'd0, product};
            end
        end else if (out_valid && ovp4) begin
            check("w4_hold", {24'd0, product}, {16'd0, held4});
        end
        ovp4 = out_valid;
    end

    // ---------------- WIDTH=8 instance ----------------
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    digit_serial_mul_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .product(product8), .busy(busy8)
    );

    logic [15:0] pend8;
    logic [15:0] eq8[$];
    int          cq8[$];
    logic        ovp8 = 1'b0;
    logic [15:0] e8;
    int          c8;

    always @(posedge clk)
        if (rst_n && in_valid8 && in_ready8) begin
            eq8.push_back(pend8);
            cq8.push_back(cyc);
        end

    always @(negedge clk) begin
        if (out_valid8 && !ovp8) begin
            if (eq8.size() == 0) check("w8_unexpected_out_valid", 1, 0);
            else begin
                e8 = eq8.pop_front();
                c8 = cq8.pop_front();
                check("w8_product", {16'd0, product8}, {16'd0, e8});
                check("w8_latency", cyc - c8 - 1, 16);
            end
        end
        ovp8 = out_valid8;
    end

    // ---------------- drivers ----------------
    task automatic issue4(input logic [3:0] av, input logic [3:0] bv, input logic [15:0] ex);
        int n = 0;
        @(negedge clk);
        a = av; b = bv; pend4 = ex; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("w4_accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("w4_back_to_idle", {31'd0, in_ready}, 1);
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ex);
        int n = 0;
        @(negedge clk);
        a8 = av; b8 = bv; pend8 = ex; in_valid8 = 1'b1;
        while (!in_ready8 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("w8_accept_timeout", 0, 1);
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (!in_ready8 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("w8_idle_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0; pend4 = '0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1; pend8 = '0;
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_product", {24'd0, product}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Max operands; ready drops right after acceptance.
        issue4(4'd15, 4'd15, 16'd225);
        check("w4_in_ready_drop", {31'd0, in_ready}, 0);
        check("w4_busy_calc", {31'd0, busy}, 1);
        wait_idle4();

        // No early exit on zero operands.
        issue4(4'd10, 4'd6, 16'd60);
        wait_idle4();
        issue4(4'd0, 4'd13, 16'd0);
        wait_idle4();

        // Back-pressure: result held, extra in_valid ignored.
        out_ready = 1'b0;
        issue4(4'd7, 4'd9, 16'd63);
        for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid", {31'd0, out_valid}, 1);
            check("bp_product", {24'd0, product}, 63);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            if (k == 3) begin a = 4'd3; b = 4'd3; in_valid = 1'b1; end
            if (k == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_consumed_out_valid", {31'd0, out_valid}, 0);
        check("bp_consumed_in_ready", {31'd0, in_ready}, 1);
        check("bp_product_kept", {24'd0, product}, 63);
        issue4(4'd2, 4'd11, 16'd22);
        wait_idle4();

        // Operands change during CALC.
        issue4(4'd12, 4'd11, 16'd132);
        a = 4'd0; b = 4'd0;
        wait_idle4();

        // Reset in the middle of CALC.
        issue4(4'd9, 4'd9, 16'd81);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 1);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_product", {24'd0, product}, 0);
        eq4.delete(); cq4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_pulse", {31'd0, out_valid}, 0);
        issue4(4'd5, 4'd5, 16'd25);
        wait_idle4();

        // WIDTH=8: directed max then a random sweep against a*b.
        issue8(8'd255, 8'd255, 16'd65025);
        wait_idle8();
        issue8(8'd200, 8'd3, 16'd600);
        wait_idle8();
        for (int k = 0; k < 500; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue8(ra, rb, 16'(ra) * 16'(rb));
            wait_idle8();
        end

        for (int k = 0; k < 50 && (eq4.size() + eq8.size()) != 0; k++) @(negedge clk);
        check("scoreboard_drained", eq4.size() + eq8.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
